// File: rtl/motor_mixer_pkg.sv
// motor_mixer_pkg: widths, one-hot mixer states and the X-quad sign table
// shared by motor_mixer and its mix_clamp datapath.
package motor_mixer_pkg;

    localparam int PID_RATE_BIT_WIDTH   = 16;
    localparam int MOTOR_RATE_BIT_WIDTH = 16;
    localparam int MIX_SUM_WIDTH        = 19;

    typedef enum logic [2:0] {
        WAITING  = 3'b001,
        MIX      = 3'b010,
        COMPLETE = 3'b100
    } mixer_state_t;

    // Bit set means the term is subtracted for that motor.
    typedef struct packed {
        logic roll_neg;
        logic pitch_neg;
        logic yaw_neg;
    } mix_signs_t;

    // idx 0..3 selects motor 1..4 (FR, FL, RL, RR).
    function automatic mix_signs_t motor_signs(input logic [1:0] idx);
        mix_signs_t s;
        case (idx)
            2'd0:    s = mix_signs_t'(3'b100); // M1 = T - R + P + Y
            2'd1:    s = mix_signs_t'(3'b001); // M2 = T + R + P - Y
            2'd2:    s = mix_signs_t'(3'b010); // M3 = T + R - P + Y
            default: s = mix_signs_t'(3'b111); // M4 = T - R - P - Y
        endcase
        return s;
    endfunction

endpackage

// File: rtl/motor_mixer_mix_clamp.sv
// mix_clamp: combinational sign-select, sum and saturate for one motor.
// Instantiated once in motor_mixer and time-shared across the four motors.
module mix_clamp
    import motor_mixer_pkg::*;
#(
    parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MIN  = 16'd0,
    parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MAX  = 16'hFFFF,
    parameter int unsigned                     RATE_SHIFT = 0
) (
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] throttle,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   yaw_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   roll_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   pitch_rate,
    input  logic                            roll_neg,
    input  logic                            pitch_neg,
    input  logic                            yaw_neg,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_rate,
    output logic                            saturated
);

    localparam int RATE_EXT = MIX_SUM_WIDTH - PID_RATE_BIT_WIDTH;
    localparam int THR_EXT  = MIX_SUM_WIDTH - MOTOR_RATE_BIT_WIDTH;

    localparam logic signed [MIX_SUM_WIDTH-1:0] MIN_S = {{THR_EXT{1'b0}}, MOTOR_MIN};
    localparam logic signed [MIX_SUM_WIDTH-1:0] MAX_S = {{THR_EXT{1'b0}}, MOTOR_MAX};

    logic signed [MIX_SUM_WIDTH-1:0] thr_ext;
    logic signed [MIX_SUM_WIDTH-1:0] roll_ext, pitch_ext, yaw_ext;
    logic signed [MIX_SUM_WIDTH-1:0] roll_term, pitch_term, yaw_term;
    logic signed [MIX_SUM_WIDTH-1:0] sum;

    // Extend, scale and sign-select each term, then sum and clamp.
    always_comb begin
        thr_ext    = signed'({{THR_EXT{1'b0}}, throttle});
        roll_ext   = signed'({{RATE_EXT{roll_rate[PID_RATE_BIT_WIDTH-1]}},  roll_rate})  >>> RATE_SHIFT;
        pitch_ext  = signed'({{RATE_EXT{pitch_rate[PID_RATE_BIT_WIDTH-1]}}, pitch_rate}) >>> RATE_SHIFT;
        yaw_ext    = signed'({{RATE_EXT{yaw_rate[PID_RATE_BIT_WIDTH-1]}},   yaw_rate})   >>> RATE_SHIFT;
        roll_term  = roll_neg  ? -roll_ext  : roll_ext;
        pitch_term = pitch_neg ? -pitch_ext : pitch_ext;
        yaw_term   = yaw_neg   ? -yaw_ext   : yaw_ext;
        sum        = thr_ext + roll_term + pitch_term + yaw_term;

        motor_rate = sum[MOTOR_RATE_BIT_WIDTH-1:0];
        saturated  = 1'b0;
        if (sum < MIN_S) begin
            motor_rate = MOTOR_MIN;
            saturated  = 1'b1;
        end else if (sum > MAX_S) begin
            motor_rate = MOTOR_MAX;
            saturated  = 1'b1;
        end
    end

endmodule

// File: rtl/motor_mixer.sv
// motor_mixer: X-quad mixer. Latches throttle and body rates on start_signal,
// mixes one motor per cycle through a shared mix_clamp, then publishes all
// four drive values with a one-cycle complete_signal.
// Optional: define MOTOR_MIXER_ARM_EN to add the 'armed' input; when the
// latched armed is 0 every output is MOTOR_MIN and saturated is 0.
module motor_mixer
    import motor_mixer_pkg::*;
#(
    parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MIN  = 16'd0,
    parameter logic [MOTOR_RATE_BIT_WIDTH-1:0] MOTOR_MAX  = 16'hFFFF,
    parameter int unsigned                     RATE_SHIFT = 0
) (
    input  logic                            us_clk,
    input  logic                            reset,
    input  logic                            start_signal,
`ifdef MOTOR_MIXER_ARM_EN
    input  logic                            armed,
`endif
    input  logic [MOTOR_RATE_BIT_WIDTH-1:0] throttle,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   yaw_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   roll_rate,
    input  logic [PID_RATE_BIT_WIDTH-1:0]   pitch_rate,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_1_rate,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_2_rate,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_3_rate,
    output logic [MOTOR_RATE_BIT_WIDTH-1:0] motor_4_rate,
    output logic [3:0]                      saturated,
    output logic                            complete_signal,
    output logic                            busy
);

    mixer_state_t state, state_next;

    logic [1:0]                      idx;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] thr_q;
    logic [PID_RATE_BIT_WIDTH-1:0]   yaw_q, roll_q, pitch_q;
    logic                            armed_q;
    logic                            arm_in;
    logic [MOTOR_RATE_BIT_WIDTH-1:0] shadow_rate [4];
    logic [3:0]                      shadow_sat;

    logic [MOTOR_RATE_BIT_WIDTH-1:0] mc_rate;
    logic                            mc_sat;
    mix_signs_t                      signs;

`ifdef MOTOR_MIXER_ARM_EN
    assign arm_in = armed;
`else
    assign arm_in = 1'b1;
`endif

    assign signs = motor_signs(idx);
    assign busy  = (state != WAITING);

    mix_clamp #(
        .MOTOR_MIN  (MOTOR_MIN),
        .MOTOR_MAX  (MOTOR_MAX),
        .RATE_SHIFT (RATE_SHIFT)
    ) u_mix_clamp (
        .throttle   (thr_q),
        .yaw_rate   (yaw_q),
        .roll_rate  (roll_q),
        .pitch_rate (pitch_q),
        .roll_neg   (signs.roll_neg),
        .pitch_neg  (signs.pitch_neg),
        .yaw_neg    (signs.yaw_neg),
        .motor_rate (mc_rate),
        .saturated  (mc_sat)
    );

    // State register.
    always_ff @(posedge us_clk) begin
        if (reset) state <= WAITING;
        else       state <= state_next;
    end

    // Next-state logic; start is only honoured in WAITING.
    always_comb begin
        state_next = state;
        case (state)
            WAITING:  if (start_signal) state_next = MIX;
            MIX:      if (idx == 2'd3)  state_next = COMPLETE;
            COMPLETE: state_next = WAITING;
            default:  state_next = WAITING;
        endcase
    end

    // Input latch, per-motor shadow fill and output publish.
    always_ff @(posedge us_clk) begin
        if (reset) begin
            idx             <= '0;
            thr_q           <= '0;
            yaw_q           <= '0;
            roll_q          <= '0;
            pitch_q         <= '0;
            armed_q         <= 1'b0;
            shadow_sat      <= '0;
            for (int unsigned i = 0; i < 4; i++) shadow_rate[i] <= '0;
            motor_1_rate    <= '0;
            motor_2_rate    <= '0;
            motor_3_rate    <= '0;
            motor_4_rate    <= '0;
            saturated       <= '0;
            complete_signal <= 1'b0;
        end else begin
            complete_signal <= 1'b0;
            case (state)
                WAITING: begin
                    if (start_signal) begin
                        thr_q   <= throttle;
                        yaw_q   <= yaw_rate;
                        roll_q  <= roll_rate;
                        pitch_q <= pitch_rate;
                        armed_q <= arm_in;
                        idx     <= '0;
                    end
                end
                MIX: begin
                    shadow_rate[idx] <= mc_rate;
                    shadow_sat[idx]  <= mc_sat;
                    idx              <= idx + 2'd1;
                end
                COMPLETE: begin
                    complete_signal <= 1'b1;
                    if (armed_q) begin
                        motor_1_rate <= shadow_rate[0];
                        motor_2_rate <= shadow_rate[1];
                        motor_3_rate <= shadow_rate[2];
                        motor_4_rate <= shadow_rate[3];
                        saturated    <= shadow_sat;
                    end else begin
                        motor_1_rate <= MOTOR_MIN;
                        motor_2_rate <= MOTOR_MIN;
                        motor_3_rate <= MOTOR_MIN;
                        motor_4_rate <= MOTOR_MIN;
                        saturated    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_motor_mixer.sv
// tb_motor_mixer: directed scoreboard bench for motor_mixer. Two instances
// share the stimulus: RATE_SHIFT=0 and RATE_SHIFT=2.
module tb_motor_mixer;

    logic        us_clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_signal = 1'b0;
    logic        arm_val = 1'b1;
    logic [15:0] throttle = '0, yaw_rate = '0, roll_rate = '0, pitch_rate = '0;

    logic [15:0] ma1, ma2, ma3, ma4, mb1, mb2, mb3, mb4;
    logic [3:0]  sat_a, sat_b;
    logic        cmp_a, cmp_b, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0][15:0] m;
        logic [3:0]       sat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    always #500 us_clk = ~us_clk;

    motor_mixer #(.MOTOR_MIN(16'd0), .MOTOR_MAX(16'hFFFF), .RATE_SHIFT(0)) dut_a (
        .us_clk(us_clk), .reset(reset), .start_signal(start_signal),
`ifdef MOTOR_MIXER_ARM_EN
        .armed(arm_val),
`endif
        .throttle(throttle), .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
        .motor_1_rate(ma1), .motor_2_rate(ma2), .motor_3_rate(ma3), .motor_4_rate(ma4),
        .saturated(sat_a), .complete_signal(cmp_a), .busy(busy_a)
    );

    motor_mixer #(.MOTOR_MIN(16'd0), .MOTOR_MAX(16'hFFFF), .RATE_SHIFT(2)) dut_b (
        .us_clk(us_clk), .reset(reset), .start_signal(start_signal),
`ifdef MOTOR_MIXER_ARM_EN
        .armed(arm_val),
`endif
        .throttle(throttle), .yaw_rate(yaw_rate), .roll_rate(roll_rate), .pitch_rate(pitch_rate),
        .motor_1_rate(mb1), .motor_2_rate(mb2), .motor_3_rate(mb3), .motor_4_rate(mb4),
        .saturated(sat_b), .complete_signal(cmp_b), .busy(busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference mix in plain 32-bit integers.
    function automatic exp_t model(input logic [15:0] t, r, p, y, input int sh, input logic arm);
        exp_t e;
        int ti, ri, pv, yi;
        int s[4];
        ti = int'({16'd0, t});
        ri = int'($signed(r)) >>> sh;
        pv = int'($signed(p)) >>> sh;
        yi = int'($signed(y)) >>> sh;
        s[0] = ti - ri + pv + yi;
        s[1] = ti + ri + pv - yi;
        s[2] = ti + ri - pv + yi;
        s[3] = ti - ri - pv - yi;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            if (!arm) begin
                e.m[k] = 16'd0;
            end else if (s[k] < 0) begin
                e.m[k] = 16'd0;     e.sat[k] = 1'b1;
            end else if (s[k] > 65535) begin
                e.m[k] = 16'hFFFF;  e.sat[k] = 1'b1;
            end else begin
                e.m[k] = s[k][15:0];
            end
        end
        return e;
    endfunction

    task automatic check_outputs(input string tag);
        exp_t ea, eb;
        logic [3:0][15:0] oa, ob;
        oa = {ma4, ma3, ma2, ma1};
        ob = {mb4, mb3, mb2, mb1};
        check({tag, "_qa_depth"}, q_a.size(), 1);
        check({tag, "_qb_depth"}, q_b.size(), 1);
        if (q_a.size() > 0 && q_b.size() > 0) begin
            ea = q_a.pop_front();
            eb = q_b.pop_front();
            for (int k = 0; k < 4; k++) begin
                check($sformatf("%s_a_m%0d", tag, k + 1), oa[k], ea.m[k]);
                check($sformatf("%s_b_m%0d", tag, k + 1), ob[k], eb.m[k]);
            end
            check({tag, "_a_sat"}, sat_a, ea.sat);
            check({tag, "_b_sat"}, sat_b, eb.sat);
        end
    endtask

    // Drives one start at the current negedge and waits for completion.
    // inject>0 raises a junk start on that cycle, which must be ignored.
    task automatic run_txn(input string tag, input logic [15:0] t, r, p, y, input int inject);
        int cyc;
        throttle = t; roll_rate = r; pitch_rate = p; yaw_rate = y;
        start_signal = 1'b1;
        q_a.push_back(model(t, r, p, y, 0, arm_val));
        q_b.push_back(model(t, r, p, y, 2, arm_val));
        cyc = 0;
        do begin
            @(negedge us_clk);
            cyc++;
            start_signal = (cyc == inject);
            if (cyc == inject) begin
                throttle = 16'h1234; roll_rate = 16'h7000; pitch_rate = 16'h8123; yaw_rate = 16'h0F00;
            end
            if (cyc == 1) check({tag, "_cmp_low_e0"}, cmp_a, 0);
            if (inject > 0 && cyc < 6) check($sformatf("%s_busy_c%0d", tag, cyc), busy_a, 1);
        end while (!cmp_a && cyc < 20);
        check({tag, "_latency"}, cyc, 6);
        check({tag, "_cmp_b"}, cmp_b, 1);
        check({tag, "_busy_done"}, busy_a, 0);
        check_outputs(tag);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int seen;
        repeat (3) @(negedge us_clk);
        reset = 1'b0;
        @(negedge us_clk);
        check("rst_m1", ma1, 0);
        check("rst_m4", ma4, 0);
        check("rst_sat", sat_a, 0);
        check("rst_cmp", cmp_a, 0);
        check("rst_busy", busy_a, 0);

        run_txn("roll_pos", 16'd1000, 16'd100, 16'd0, 16'd0, 0);
        check("roll_pos_m1_lit", ma1, 900);
        check("roll_pos_m2_lit", ma2, 1100);
        @(negedge us_clk);
        check("roll_pos_cmp_fall", cmp_a, 0);
        check("roll_pos_hold_m2", ma2, 1100);

        run_txn("roll_neg", 16'd10, -16'sd100, 16'd0, 16'd0, 0);
        check("roll_neg_sat_lit", sat_a, 4'b0110);

        run_txn("yaw_hi", 16'd65500, 16'd0, 16'd0, 16'd100, 0);
        check("yaw_hi_sat_lit", sat_a, 4'b0101);
        check("yaw_hi_b_m1_lit", mb1, 65525);
        check("yaw_hi_b_sat_lit", sat_b, 4'b0000);

        // Ignored start at E2, then back-to-back start accepted at E6.
        run_txn("busy_ign", 16'd3000, 16'd200, -16'sd300, 16'd400, 2);
        run_txn("b2b", 16'd40000, -16'sd32768, 16'd32767, -16'sd5, 0);

        // Reset asserted at E3 aborts the transaction.
        @(negedge us_clk);
        throttle = 16'd2000; roll_rate = 16'd50; start_signal = 1'b1;
        @(negedge us_clk); start_signal = 1'b0;
        @(negedge us_clk);
        @(negedge us_clk); reset = 1'b1;
        @(negedge us_clk); reset = 1'b0;
        check("abort_m1", ma1, 0);
        check("abort_m3", ma3, 0);
        check("abort_sat", sat_a, 0);
        check("abort_busy", busy_a, 0);
        seen = 0;
        repeat (8) begin
            if (cmp_a || cmp_b) seen++;
            @(negedge us_clk);
        end
        check("abort_no_cmp", seen, 0);
        run_txn("after_abort", 16'd2000, 16'd50, 16'd25, -16'sd10, 0);

        for (int n = 0; n < 4; n++) begin
            run_txn($sformatf("rand%0d", n), 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 0);
        end

`ifdef MOTOR_MIXER_ARM_EN
        arm_val = 1'b0;
        run_txn("disarmed", 16'd5000, 16'd300, 16'd0, 16'd0, 0);
        check("disarmed_m1_lit", ma1, 0);
        arm_val = 1'b1;
        run_txn("armed", 16'd5000, 16'd300, 16'd0, 16'd0, 0);
        check("armed_m1_lit", ma1, 4700);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
